// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register of the 5-stage MIPS core.
// Captures the decoded instruction each edge, inserts a bubble when decode
// is stalled, and provides the saturating-decremented Tnew for the E/M stage.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_RS,
    input  logic [31:0] D_RT,
    input  logic [31:0] D_ext,
    input  logic [4:0]  D_A3,
    input  logic [1:0]  D_Tnew,
    output logic [31:0] E_PC,
    output logic [31:0] E_instr,
    output logic [31:0] E_RS,
    output logic [31:0] E_RT,
    output logic [31:0] E_ext,
    output logic [4:0]  E_A3,
    output logic [1:0]  E_Tnew,
    output logic [1:0]  E_Tnew_dec,
    output logic        E_valid,
    output logic [31:0] bubble_cnt
);

    localparam int unsigned WordW = 32;
    localparam int unsigned RegW  = 5;
    localparam int unsigned TnewW = 2;

    logic [WordW-1:0] pc_q, instr_q, rs_q, rt_q, ext_q;
    logic [RegW-1:0]  a3_q;
    logic [TnewW-1:0] tnew_q;
    logic             valid_q;

    // Stage register: reset clears, stall loads a bubble (PC kept), else capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            ext_q   <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
        end else if (stall) begin
            pc_q    <= D_PC;
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            ext_q   <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= D_PC;
            instr_q <= D_instr;
            rs_q    <= D_RS;
            rt_q    <= D_RT;
            ext_q   <= D_ext;
            a3_q    <= D_A3;
            // A non-writing instruction never advertises a pending result.
            tnew_q  <= (D_A3 == RegW'(0)) ? TnewW'(0) : D_Tnew;
            valid_q <= 1'b1;
        end
    end

    assign E_PC    = pc_q;
    assign E_instr = instr_q;
    assign E_RS    = rs_q;
    assign E_RT    = rt_q;
    assign E_ext   = ext_q;
    assign E_A3    = a3_q;
    assign E_Tnew  = tnew_q;
    assign E_valid = valid_q;

    // Saturating decrement of the in-flight Tnew; never wraps to 3.
    always_comb begin
        E_Tnew_dec = TnewW'(0);
        if (tnew_q != TnewW'(0)) begin
            E_Tnew_dec = tnew_q - TnewW'(1);
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [WordW-1:0] bubble_cnt_q, bubble_cnt_d;

    // Next bubble count: +1 per stalled edge, sticking at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (stall && (bubble_cnt_q != {WordW{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + WordW'(1);
        end
    end

    // Bubble counter register; reset takes priority over a concurrent stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed bench for id_ex_reg with a transaction-level model
// compared every cycle, plus literal expectations at key points.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] D_PC, D_instr, D_RS, D_RT, D_ext;
    logic [4:0]  D_A3;
    logic [1:0]  D_Tnew;
    logic [31:0] E_PC, E_instr, E_RS, E_RT, E_ext, bubble_cnt;
    logic [4:0]  E_A3;
    logic [1:0]  E_Tnew, E_Tnew_dec;
    logic        E_valid;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .stall(stall),
        .D_PC(D_PC), .D_instr(D_instr), .D_RS(D_RS), .D_RT(D_RT),
        .D_ext(D_ext), .D_A3(D_A3), .D_Tnew(D_Tnew),
        .E_PC(E_PC), .E_instr(E_instr), .E_RS(E_RS), .E_RT(E_RT),
        .E_ext(E_ext), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_Tnew_dec(E_Tnew_dec),
        .E_valid(E_valid), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Model of what sits in E: one record per edge, built from the rules.
    typedef struct {
        logic [31:0] pc, instr, rs, rt, ext;
        int          a3, tnew;
        bit          valid;
    } e_slot_t;

    e_slot_t     m;
    longint      m_cnt = 0;
    bit          m_ok = 1'b0;
`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            m = '{pc: 0, instr: 0, rs: 0, rt: 0, ext: 0, a3: 0, tnew: 0, valid: 0};
            m_cnt = 0;
        end else if (stall) begin
            m = '{pc: D_PC, instr: 0, rs: 0, rt: 0, ext: 0, a3: 0, tnew: 0, valid: 0};
            if (CntEn && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            m = '{pc: D_PC, instr: D_instr, rs: D_RS, rt: D_RT, ext: D_ext,
                  a3: int'(D_A3), tnew: (D_A3 == 0) ? 0 : int'(D_Tnew), valid: 1};
        end
        m_ok = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            int dec;
            dec = (m.tnew == 0) ? 0 : m.tnew - 1;
            chk("m_E_PC",      E_PC,               m.pc);
            chk("m_E_instr",   E_instr,            m.instr);
            chk("m_E_RS",      E_RS,               m.rs);
            chk("m_E_RT",      E_RT,               m.rt);
            chk("m_E_ext",     E_ext,              m.ext);
            chk("m_E_A3",      32'(E_A3),          32'(m.a3));
            chk("m_E_Tnew",    32'(E_Tnew),        32'(m.tnew));
            chk("m_E_Tnew_dec",32'(E_Tnew_dec),    32'(dec));
            chk("m_E_valid",   32'(E_valid),       32'(m.valid));
            chk("m_bubble_cnt",bubble_cnt,         m_cnt[31:0]);
        end
    end

    task automatic drive(input logic rst, input logic stl, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext,
                         input logic [4:0] a3, input logic [1:0] tn);
        reset = rst; stall = stl; D_PC = pc; D_instr = ins; D_RS = rs;
        D_RT = rt; D_ext = ext; D_A3 = a3; D_Tnew = tn;
    endtask

    // Advance one edge and land on the following falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, 32'h3000, 32'h2408_0005, 32'h1, 32'h2, 32'h5, 5'd5, 2'd1);
        tick; tick;
        chk("rst_E_PC", E_PC, 32'h0);
        chk("rst_E_A3", 32'(E_A3), 32'h0);
        chk("rst_E_valid", 32'(E_valid), 32'h0);
        chk("rst_cnt", bubble_cnt, 32'h0);

        drive(1'b1, 1'b0, 32'h3004, 32'h8c08_0004, 32'h1234_5678, 32'hCAFE_0001,
              32'h4, 5'd8, 2'd2);
        tick;
        chk("cap_E_PC", E_PC, 32'h3004);
        chk("cap_E_RS", E_RS, 32'h1234_5678);
        chk("cap_E_A3", 32'(E_A3), 32'd8);
        chk("cap_E_Tnew", 32'(E_Tnew), 32'd2);
        chk("cap_E_Tnew_dec", 32'(E_Tnew_dec), 32'd1);
        chk("cap_E_valid", 32'(E_valid), 32'd1);

        drive(1'b1, 1'b0, 32'h3008, 32'hac08_0000, 32'h11, 32'h22, 32'h0, 5'd0, 2'd2);
        tick;
        chk("norm_E_Tnew", 32'(E_Tnew), 32'd0);
        chk("norm_E_Tnew_dec", 32'(E_Tnew_dec), 32'd0);

        drive(1'b1, 1'b0, 32'h300c, 32'h0109_5021, 32'h33, 32'h44, 32'h0, 5'd10, 2'd1);
        tick;
        chk("t1_E_Tnew_dec", 32'(E_Tnew_dec), 32'd0);

        drive(1'b1, 1'b0, 32'h3010, 32'h0109_5021, 32'h55, 32'h66, 32'h0, 5'd4, 2'd3);
        tick;
        chk("t3_E_Tnew", 32'(E_Tnew), 32'd3);
        chk("t3_E_Tnew_dec", 32'(E_Tnew_dec), 32'd2);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h3008, 32'h8c09_0000, 32'h77, 32'h88, 32'h9, 5'd9, 2'd2);
            tick;
            chk("stl_E_PC", E_PC, 32'h3008);
            chk("stl_E_instr", E_instr, 32'h0);
            chk("stl_E_A3", 32'(E_A3), 32'h0);
            chk("stl_E_valid", 32'(E_valid), 32'h0);
        end
        chk("stl_cnt", bubble_cnt, CntEn ? 32'd3 : 32'd0);

        drive(1'b1, 1'b1, 32'h300c, 32'h8c09_0000, 32'h77, 32'h88, 32'h9, 5'd9, 2'd2);
        tick;
        chk("stl4_E_PC", E_PC, 32'h300c);
        chk("stl4_cnt", bubble_cnt, CntEn ? 32'd4 : 32'd0);

        drive(1'b0, 1'b1, 32'h3010, 32'h8c09_0000, 32'h77, 32'h88, 32'h9, 5'd9, 2'd2);
        tick;
        chk("rstst_E_PC", E_PC, 32'h0);
        chk("rstst_cnt", bubble_cnt, 32'h0);

        drive(1'b1, 1'b1, 32'h3014, 32'h0000_0020, 32'h1, 32'h2, 32'h3, 5'd2, 2'd1);
        tick;
        chk("rel_E_PC", E_PC, 32'h3014);
        chk("rel_E_valid", 32'(E_valid), 32'h0);
        chk("rel_cnt", bubble_cnt, CntEn ? 32'd1 : 32'd0);

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'(i == 3), 32'h4000 + 32'(4 * i), $urandom, $urandom, $urandom,
                  $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)));
            tick;
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 64'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h5000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0);
            tick;
        end
        chk("sat_cnt", bubble_cnt, 32'hFFFF_FFFF);
`endif

        drive(1'b1, 1'b0, 32'h6000, 32'h1, 32'h2, 32'h3, 32'h4, 5'd31, 2'd1);
        tick;
        chk("end_E_A3", 32'(E_A3), 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
